// File: rtl/elevator_floor_scheduler.sv
// Single-car SCAN elevator scheduler: latches floor calls, times travel and door dwell.
// Build macro EMERGENCY_STOP_EN adds an estop input and stopped output that freeze the car.
module elevator_floor_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] call,
`ifdef EMERGENCY_STOP_EN
  input  logic       estop,
  output logic       stopped,
`endif
  output logic [2:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       arrive,
  output logic [7:0] pending
);

  localparam int            TW          = $clog2(TRAVEL_TICKS + 1);
  localparam int            DW          = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);
  localparam logic [7:0]    FLOOR_MASK  = 8'((16'd1 << NUM_FLOORS) - 16'd1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  typedef enum logic       {DIR_UP, DIR_DOWN} dir_t;

  state_t        state, state_nxt;
  dir_t          dir_pref;
  logic [TW-1:0] timer;
  logic [DW-1:0] door_timer;
  logic [2:0]    floor_nxt;
  logic [7:0]    call_masked, clr, pending_nxt;
  logic          freeze, door_restart, travel_done;

  function automatic logic any_above(input logic [7:0] req, input logic [2:0] f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i > int'(f) && req[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic any_below(input logic [7:0] req, input logic [2:0] f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i < int'(f) && req[i]) hit = 1'b1;
    return hit;
  endfunction

  // Decision taken on the floor just reached: stop, keep going, reverse, or rest.
  function automatic state_t arrival_state(input logic [7:0] req, input logic [2:0] f,
                                           input logic up);
    if (req[f]) return DOOR_OPEN;
    if (up ? any_above(req, f) : any_below(req, f)) return up ? MOVE_UP : MOVE_DOWN;
    if (up ? any_below(req, f) : any_above(req, f)) return up ? MOVE_DOWN : MOVE_UP;
    return IDLE;
  endfunction

`ifdef EMERGENCY_STOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    call_masked  = call & FLOOR_MASK;
    travel_done  = (timer == TRAVEL_LAST);
    door_restart = (state == DOOR_OPEN) && call_masked[floor];
    state_nxt    = state;
    floor_nxt    = floor;
    case (state)
      IDLE: begin
        if (pending != 8'd0) begin
          if (pending[floor])
            state_nxt = DOOR_OPEN;
          else if (any_above(pending, floor) &&
                   (dir_pref == DIR_UP || !any_below(pending, floor)))
            state_nxt = MOVE_UP;
          else
            state_nxt = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (!any_above(pending, floor)) begin
          state_nxt = IDLE;
        end else if (travel_done) begin
          floor_nxt = floor + 3'd1;
          state_nxt = arrival_state(pending, floor_nxt, 1'b1);
        end
      end
      MOVE_DOWN: begin
        if (!any_below(pending, floor)) begin
          state_nxt = IDLE;
        end else if (travel_done) begin
          floor_nxt = floor - 3'd1;
          state_nxt = arrival_state(pending, floor_nxt, 1'b0);
        end
      end
      DOOR_OPEN: begin
        if (door_timer == DOOR_LAST && !door_restart) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (freeze) begin
      state_nxt = state;
      floor_nxt = floor;
    end
    // The stop floor is cleared while opening and while open, so a same-floor call never sticks.
    clr = (state == DOOR_OPEN || state_nxt == DOOR_OPEN) ? (8'd1 << floor_nxt) : 8'd0;
    pending_nxt = (pending | call_masked) & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dir_pref    <= DIR_UP;
      floor       <= 3'd0;
      pending     <= 8'd0;
      timer       <= '0;
      door_timer  <= '0;
      arrive      <= 1'b0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
`ifdef EMERGENCY_STOP_EN
      stopped     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state       <= state_nxt;
      floor       <= floor_nxt;
      pending     <= pending_nxt;
      arrive      <= (floor_nxt != floor);
      moving_up   <= (state_nxt == MOVE_UP);
      moving_down <= (state_nxt == MOVE_DOWN);
      door_open   <= (state_nxt == DOOR_OPEN);
      if (floor_nxt != floor) dir_pref <= (state == MOVE_UP) ? DIR_UP : DIR_DOWN;
      if (!freeze) begin
        timer <= (state_nxt == state && (state == MOVE_UP || state == MOVE_DOWN) &&
                  floor_nxt == floor) ? timer + 1'b1 : '0;
        door_timer <= (state == DOOR_OPEN && state_nxt == DOOR_OPEN && !door_restart) ?
                      door_timer + 1'b1 : '0;
      end
`ifdef EMERGENCY_STOP_EN
      stopped     <= estop;
`endif
    end
  end

endmodule

// File: tb/tb_elevator_floor_scheduler.sv
// Scoreboard bench for elevator_floor_scheduler: countdown-based car model predicts each cycle.
// Honours EMERGENCY_STOP_EN when the design is built with it.
`timescale 1ns/1ps
module tb_elevator_floor_scheduler;

  localparam int         NUM_FLOORS   = 8;
  localparam int         TRAVEL_TICKS = 4;
  localparam int         DOOR_TICKS   = 3;
  localparam logic [7:0] FLOOR_MASK   = 8'((16'd1 << NUM_FLOORS) - 16'd1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] call = 8'd0;
  logic [2:0] floor;
  logic       moving_up, moving_down, door_open, arrive;
  logic [7:0] pending;
`ifdef EMERGENCY_STOP_EN
  logic       estop = 1'b0;
  logic       stopped;
`endif

  elevator_floor_scheduler #(
    .NUM_FLOORS(NUM_FLOORS), .TRAVEL_TICKS(TRAVEL_TICKS), .DOOR_TICKS(DOOR_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call(call),
`ifdef EMERGENCY_STOP_EN
    .estop(estop), .stopped(stopped),
`endif
    .floor(floor), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .arrive(arrive), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] floor;
    logic       up, down, door, arrive;
    logic [7:0] pending;
    logic       stopped;
  } obs_t;

  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];

  // Car model: position, direction mode, and countdowns of cycles left to travel / dwell.
  int         m_floor;
  logic [7:0] m_pending;
  mode_t      m_mode;
  int         m_left, m_door_left;
  bit         m_pref_up, m_arrive;
  logic [7:0] applied_call = 8'd0;
  bit         applied_stop = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit req_above(input int f);
    for (int i = f + 1; i < NUM_FLOORS; i++) if (m_pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit req_below(input int f);
    for (int i = 0; i < f; i++) if (m_pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_pending = 8'd0; m_mode = M_IDLE;
    m_left = 0; m_door_left = 0; m_pref_up = 1'b1; m_arrive = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] c, input bit stop);
    logic [7:0] cm, clr;
    int         nf;
    mode_t      nm;
    bit         up;
    obs_t       e;
    cm = c & FLOOR_MASK;
    nf = m_floor;
    nm = m_mode;
    m_arrive = 1'b0;
    if (!stop) begin
      case (m_mode)
        M_IDLE: if (m_pending != 8'd0) begin
          if (m_pending[m_floor]) begin
            nm = M_DOOR; m_door_left = DOOR_TICKS;
          end else if (req_above(m_floor) && (m_pref_up || !req_below(m_floor))) begin
            nm = M_UP; m_left = TRAVEL_TICKS;
          end else begin
            nm = M_DOWN; m_left = TRAVEL_TICKS;
          end
        end
        M_UP, M_DOWN: begin
          up = (m_mode == M_UP);
          if (up ? !req_above(m_floor) : !req_below(m_floor)) begin
            nm = M_IDLE;
          end else if (m_left > 1) begin
            m_left--;
          end else begin
            nf = up ? m_floor + 1 : m_floor - 1;
            m_arrive = 1'b1;
            m_pref_up = up;
            if (m_pending[nf]) begin
              nm = M_DOOR; m_door_left = DOOR_TICKS;
            end else if (up ? req_above(nf) : req_below(nf)) begin
              m_left = TRAVEL_TICKS;
            end else if (up ? req_below(nf) : req_above(nf)) begin
              nm = up ? M_DOWN : M_UP; m_left = TRAVEL_TICKS;
            end else begin
              nm = M_IDLE;
            end
          end
        end
        M_DOOR: begin
          if (cm[m_floor]) m_door_left = DOOR_TICKS;
          else if (m_door_left == 1) nm = M_IDLE;
          else m_door_left--;
        end
        default: nm = M_IDLE;
      endcase
    end
    clr = (m_mode == M_DOOR || nm == M_DOOR) ? (8'd1 << nf) : 8'd0;
    m_pending = (m_pending | cm) & ~clr;
    m_floor = nf;
    m_mode = nm;
    e.floor = 3'(m_floor);
    e.up = (m_mode == M_UP);
    e.down = (m_mode == M_DOWN);
    e.door = (m_mode == M_DOOR);
    e.arrive = m_arrive;
    e.pending = m_pending;
    e.stopped = stop;
    exp_q.push_back(e);
  endtask

  function automatic obs_t sample_dut();
    obs_t a;
    a.floor = floor; a.up = moving_up; a.down = moving_down; a.door = door_open;
    a.arrive = arrive; a.pending = pending;
`ifdef EMERGENCY_STOP_EN
    a.stopped = stopped;
`else
    a.stopped = 1'b0;
`endif
    return a;
  endfunction

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_obs{floor,up,down,door,arrive,pending,stopped}", 32'(sample_dut()), 32'(e));
    end
  end

  // One clock edge: predict it from the inputs the DUT just sampled, then drive new inputs.
  task automatic cycle(input logic [7:0] c, input bit stop);
    @(posedge clk);
    #1;
    model_step(applied_call, applied_stop);
    call = c;
    applied_call = c;
    applied_stop = stop;
`ifdef EMERGENCY_STOP_EN
    estop = stop;
`endif
  endtask

  int stops[$];
  task automatic run_record(input int n);
    logic prev;
    stops.delete();
    prev = door_open;
    for (int i = 0; i < n; i++) begin
      cycle(8'd0, 1'b0);
      if (door_open && !prev) stops.push_back(int'(floor));
      prev = door_open;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    logic any4;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_floor", 32'(floor), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_moving", 32'({moving_up, moving_down}), 0);
    check("reset_door", 32'(door_open), 0);
    check("reset_arrive", 32'(arrive), 0);
    #14 rst_n = 1'b1;

    // Single call to floor 3 from reset: exact latency and dwell.
    cycle(8'h08, 1'b0);
    cycle(8'h00, 1'b0);
    check("s1_latched", 32'(pending), 32'h08);
    check("s1_not_yet_moving", 32'(moving_up), 0);
    cycle(8'h00, 1'b0);
    check("s1_moving_up", 32'(moving_up), 1);
    for (int n = 2; n <= 13; n++) begin
      cycle(8'h00, 1'b0);
      if (n == 5) check("s1_floor1_at_k5", 32'(floor), 1);
      if (n == 9) check("s1_floor2_at_k9", 32'(floor), 2);
    end
    check("s1_floor3_at_k13", 32'(floor), 3);
    check("s1_arrive", 32'(arrive), 1);
    check("s1_door", 32'(door_open), 1);
    check("s1_cleared", 32'(pending), 0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    check("s1_door_k15", 32'(door_open), 1);
    cycle(8'h00, 1'b0);
    check("s1_idle_k16", 32'({door_open, moving_up, moving_down}), 0);

    // Idle at 3 preferring UP with calls 0 and 7: serve 7 first.
    cycle(8'h81, 1'b0);
    run_record(100);
    check("s4_stop_count", 32'(stops.size()), 2);
    if (stops.size() == 2) begin
      check("s4_first_stop", 32'(stops[0]), 7);
      check("s4_second_stop", 32'(stops[1]), 0);
    end

    // Heading to 6, a call for 0 arrives while passing floor 2.
    cycle(8'h40, 1'b0);
    for (int i = 0; i < 40 && !(m_floor == 2 && m_mode == M_UP); i++) cycle(8'h00, 1'b0);
    check("s2_reached_floor2", 32'(m_floor == 2 && m_mode == M_UP), 1);
    cycle(8'h01, 1'b0);
    run_record(100);
    check("s2_stop_count", 32'(stops.size()), 2);
    if (stops.size() == 2) begin
      check("s2_first_stop", 32'(stops[0]), 6);
      check("s2_second_stop", 32'(stops[1]), 0);
    end

    // Go to 4, then call 4 again while idle there and once more in dwell cycle 2.
    cycle(8'h10, 1'b0);
    run_record(40);
    cycle(8'h10, 1'b0);
    cycle(8'h00, 1'b0);
    cnt = 0;
    any4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle((i == 1) ? 8'h10 : 8'h00, 1'b0);
      if (door_open) cnt++;
      any4 |= pending[4];
      check("s3_no_motion", 32'({moving_up, moving_down}), 0);
    end
    check("s3_extended_dwell", 32'(cnt), 5);
    check("s3_bit4_never_held", 32'(any4), 0);

    // Asynchronous reset while travelling from floor 5.
    cycle(8'h80, 1'b0);
    for (int i = 0; i < 60 && !(m_floor == 5 && m_mode == M_UP && m_left == 2); i++)
      cycle(8'h00, 1'b0);
    check("s5_mid_travel_at5", 32'(floor), 5);
    #5 rst_n = 1'b0;
    #1;
    check("s5_rst_floor", 32'(floor), 0);
    check("s5_rst_pending", 32'(pending), 0);
    check("s5_rst_outputs", 32'({moving_up, moving_down, door_open, arrive}), 0);
    model_reset();
    call = 8'd0; applied_call = 8'd0; applied_stop = 1'b0;
`ifdef EMERGENCY_STOP_EN
    estop = 1'b0;
`endif
    #1 rst_n = 1'b1;

`ifdef EMERGENCY_STOP_EN
    // Freeze for 10 edges with one tick done between floors 1 and 2.
    cycle(8'h04, 1'b0);
    for (int i = 0; i < 40 && !(m_floor == 1 && m_mode == M_UP && m_left == 3); i++)
      cycle(8'h00, 1'b0);
    estop = 1'b1;
    applied_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(8'h00, i < 9);
      check("es_floor_frozen", 32'(floor), 1);
    end
    cnt = 0;
    for (int i = 0; i < 10 && floor == 3'd1; i++) begin
      cycle(8'h00, 1'b0);
      cnt++;
    end
    check("es_remaining_ticks", 32'(cnt), 3);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] c;
      bit s;
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0;
`ifdef EMERGENCY_STOP_EN
      s = ($urandom_range(0, 15) == 0);
`else
      s = 1'b0;
`endif
      cycle(c, s);
    end
    cycle(8'h00, 1'b0);
    #10;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
